// File: rtl/vs_gen_pkg.sv
// vs_gen_pkg: shared definitions for the VS generator.
//   - vs_state_e : generator state encoding (idle / pulse high / pulse low)
//   - DEF_*_BW   : default counter and input widths
//   - cfg_valid  : period/width legality check (args zero-extended to 32 bits)
package vs_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StBlank
    } vs_state_e;

    localparam int unsigned DEF_PERIOD_BW    = 24;
    localparam int unsigned DEF_WIDTH_BW     = 16;
    localparam int unsigned DEF_FRAME_CNT_BW = 16;

    // A frame needs at least one high and one low cycle.
    function automatic logic cfg_valid(input logic [31:0] period, input logic [31:0] width);
        return (width >= 32'd1) && (period >= 32'd2) && (width < period);
    endfunction

endpackage

// File: rtl/vs_edge_det.sv
// vs_edge_det: one-flop rising-edge detector.
//   clk  : clock
//   rst  : synchronous active-high reset (clears the history flop)
//   sig  : monitored signal
//   rise : high while sig is 1 and was 0 on the previous clock
module vs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/vs_gen.sv
// vs_gen: programmable vertical-sync generator.
// Produces a periodic active-high VS pulse whose period and high time are sampled into
// shadow registers at every frame start. Optional macro VS_GEN_LOCK_EN adds reference
// lock: a qualified rising edge on REF_VS_I forces an immediate frame start.
// Ports:
//   CLK_I, RST_I     : clock, synchronous active-high reset
//   GEN_EN_I         : generator enable (deassertion lets the current frame finish)
//   PERIOD_CLKNUM_I  : rise-to-rise period in clocks
//   WIDTH_CLKNUM_I   : high time in clocks
//   REF_VS_I         : reference VS            (VS_GEN_LOCK_EN only)
//   REF_STABLE_I     : reference qualified     (VS_GEN_LOCK_EN only)
//   LOCKED_O         : last start was ref-led  (VS_GEN_LOCK_EN only)
//   VS_O, VS_POS_O   : generated VS and its frame-start pulse
//   FRAME_CNT_O      : frames started since reset, wrapping
//   CFG_ERR_O        : configuration invalid at last sample
module vs_gen
    import vs_gen_pkg::*;
#(
    parameter int unsigned C_PERIOD_BW    = DEF_PERIOD_BW,
    parameter int unsigned C_WIDTH_BW     = DEF_WIDTH_BW,
    parameter int unsigned C_FRAME_CNT_BW = DEF_FRAME_CNT_BW
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      GEN_EN_I,
    input  logic [C_PERIOD_BW-1:0]    PERIOD_CLKNUM_I,
    input  logic [C_WIDTH_BW-1:0]     WIDTH_CLKNUM_I,
`ifdef VS_GEN_LOCK_EN
    input  logic                      REF_VS_I,
    input  logic                      REF_STABLE_I,
    output logic                      LOCKED_O,
`endif
    output logic                      VS_O,
    output logic                      VS_POS_O,
    output logic [C_FRAME_CNT_BW-1:0] FRAME_CNT_O,
    output logic                      CFG_ERR_O
);

    localparam logic [C_PERIOD_BW-1:0]    CntOne   = C_PERIOD_BW'(1);
    localparam logic [C_FRAME_CNT_BW-1:0] FrameOne = C_FRAME_CNT_BW'(1);

    vs_state_e                 state_q, state_d;
    logic [C_PERIOD_BW-1:0]    cnt_q, cnt_d;
    logic [C_PERIOD_BW-1:0]    period_sh_q, period_sh_d;
    logic [C_PERIOD_BW-1:0]    width_sh_q, width_sh_d;
    logic [C_FRAME_CNT_BW-1:0] frame_cnt_q, frame_cnt_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      vs_q, vs_d;
    logic                      vs_pos_q, vs_pos_d;
    logic                      valid;
    logic                      ref_hit;
    logic                      sample;
    logic                      start;

`ifdef VS_GEN_LOCK_EN
    logic ref_rise;
    logic locked_q, locked_d;

    vs_edge_det u_ref_edge (
        .clk  (CLK_I),
        .rst  (RST_I),
        .sig  (REF_VS_I),
        .rise (ref_rise)
    );

    assign ref_hit = ref_rise & REF_STABLE_I & GEN_EN_I & valid;
`else
    assign ref_hit = 1'b0;
`endif

    assign valid = cfg_valid(32'(PERIOD_CLKNUM_I), 32'(WIDTH_CLKNUM_I));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_sh_d = period_sh_q;
        width_sh_d  = width_sh_q;
        frame_cnt_d = frame_cnt_q;
        cfg_err_d   = cfg_err_q;
        sample      = 1'b0;
        start       = 1'b0;

        unique case (state_q)
            StIdle: begin
                sample = 1'b1;
            end
            StActive: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == width_sh_q - CntOne) begin
                    state_d = StBlank;
                end
            end
            StBlank: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == period_sh_q - CntOne) begin
                    sample = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // A reference hit overrides whatever the frame was doing; when it lands on a
        // natural boundary it is still just one frame start.
        if (ref_hit) begin
            start = 1'b1;
        end else if (sample) begin
            if (GEN_EN_I && valid) begin
                start = 1'b1;
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
                if (GEN_EN_I) begin
                    cfg_err_d = 1'b1;
                end
            end
        end

        if (start) begin
            state_d     = StActive;
            cnt_d       = '0;
            period_sh_d = PERIOD_CLKNUM_I;
            width_sh_d  = C_PERIOD_BW'(WIDTH_CLKNUM_I);
            frame_cnt_d = frame_cnt_q + FrameOne;
            cfg_err_d   = 1'b0;
        end

        vs_d     = (state_d == StActive);
        vs_pos_d = start;
    end

`ifdef VS_GEN_LOCK_EN
    always_comb begin
        locked_d = locked_q;
        if (start) begin
            locked_d = ref_hit;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end

    assign LOCKED_O = locked_q;
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            period_sh_q <= '0;
            width_sh_q  <= '0;
            frame_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
            vs_q        <= 1'b0;
            vs_pos_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
            width_sh_q  <= width_sh_d;
            frame_cnt_q <= frame_cnt_d;
            cfg_err_q   <= cfg_err_d;
            vs_q        <= vs_d;
            vs_pos_q    <= vs_pos_d;
        end
    end

    assign VS_O        = vs_q;
    assign VS_POS_O    = vs_pos_q;
    assign FRAME_CNT_O = frame_cnt_q;
    assign CFG_ERR_O   = cfg_err_q;

endmodule

// File: tb/tb_vs_gen.sv
// tb_vs_gen: self-checking bench for vs_gen. Compares every cycle against a frame-level
// reference model (position-in-frame arithmetic with shadowed period/width).
// Lock-mode steps are built only when VS_GEN_LOCK_EN is defined.
module tb_vs_gen;

    localparam int unsigned PBW  = 24;
    localparam int unsigned WBW  = 16;
    localparam int unsigned FCBW = 8;
`ifdef VS_GEN_LOCK_EN
    localparam bit LockBuild = 1'b1;
`else
    localparam bit LockBuild = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [PBW-1:0]  period;
    logic [WBW-1:0]  width;
    logic            ref_vs;
    logic            ref_stable;
    logic            vs, vs_pos, cfg_err, locked, vs_rise;
    logic [FCBW-1:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_edge = 1'b1;

    // Reference model state
    bit m_run, m_pulse, m_err, m_lock, m_ref_prev;
    int m_pos, m_p, m_w, m_fc;

    always #5 clk = ~clk;

    vs_gen #(
        .C_PERIOD_BW    (PBW),
        .C_WIDTH_BW     (WBW),
        .C_FRAME_CNT_BW (FCBW)
    ) dut (
        .CLK_I           (clk),
        .RST_I           (rst),
        .GEN_EN_I        (en),
        .PERIOD_CLKNUM_I (period),
        .WIDTH_CLKNUM_I  (width),
`ifdef VS_GEN_LOCK_EN
        .REF_VS_I        (ref_vs),
        .REF_STABLE_I    (ref_stable),
        .LOCKED_O        (locked),
`endif
        .VS_O            (vs),
        .VS_POS_O        (vs_pos),
        .FRAME_CNT_O     (frame_cnt),
        .CFG_ERR_O       (cfg_err)
    );

`ifndef VS_GEN_LOCK_EN
    assign locked = 1'b0;
`endif

    // Independent rising-edge view of VS_O for the VS_POS_O cross-check.
    vs_edge_det u_vs_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (vs),
        .rise (vs_rise)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_edge();
        bit valid, ref_edge, ref_hit, boundary, start;
        if (rst) begin
            m_run = 0; m_pulse = 0; m_err = 0; m_lock = 0; m_ref_prev = 0;
            m_fc = 0; m_pos = 0;
            return;
        end
        valid    = (width >= 1) && (period >= 2) && (32'(width) < 32'(period));
        ref_edge = ref_vs && !m_ref_prev;
        m_ref_prev = ref_vs;
        ref_hit  = LockBuild && ref_edge && ref_stable && en && valid;
        boundary = m_run && (m_pos == m_p - 1);
        start    = 0;
        if (ref_hit) begin
            start = 1;
        end else if (!m_run || boundary) begin
            if (en && valid) start = 1;
            else begin
                m_run = 0;
                if (en) m_err = 1;
            end
        end
        m_pulse = start;
        if (start) begin
            m_run  = 1;
            m_pos  = 0;
            m_p    = int'(period);
            m_w    = int'(width);
            m_fc   = (m_fc + 1) % (1 << FCBW);
            m_err  = 0;
            m_lock = ref_hit;
        end else if (m_run) begin
            m_pos++;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("vs", 32'(vs), 32'(m_run && (m_pos < m_w)));
            chk("vs_pos", 32'(vs_pos), 32'(m_pulse));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
            if (LockBuild) chk("locked", 32'(locked), 32'(m_lock));
            if (chk_edge) chk("vs_pos_vs_rise", 32'(vs_pos), 32'(vs_rise));
        end
    endtask

    initial begin
        int k;
        rst = 1; en = 0; period = 24'd10; width = 16'd3; ref_vs = 0; ref_stable = 0;
        step(3);
        rst = 0;

        // Basic 10/3 run: first frame starts the edge after enable.
        en = 1;
        step(25);

        // Period change at cnt=5 only affects the following frame.
        k = 0;
        while (!(m_run && m_pos == 5) && k < 40) begin step(1); k++; end
        chk("reach_pos5", 32'(m_run && m_pos == 5), 32'd1);
        period = 24'd20;
        step(45);
        period = 24'd10;

        // Enable drop at cnt=1: frame completes, no further pulses.
        k = 0;
        while (!(m_run && m_pos == 1) && k < 40) begin step(1); k++; end
        chk("reach_pos1", 32'(m_run && m_pos == 1), 32'd1);
        en = 0;
        step(30);

        // Invalid config (width == period) holds in idle with error; fix starts a frame.
        width = 16'd10; en = 1;
        step(6);
        width = 16'd4;
        step(25);

        // Boundary configs: width 1, period 2, width 0.
        period = 24'd2; width = 16'd1;
        step(10);
        width = 16'd0;
        step(6);
        period = 24'd5; width = 16'd4;
        step(12);

        // Randomized config/enable churn.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                period = 24'($urandom_range(0, 12));
                width  = 16'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 19) == 0) en = ($urandom_range(0, 3) != 0);
            step(1);
        end

        // Frame counter wrap with fastest legal frames.
        rst = 1; step(1); rst = 0;
        period = 24'd2; width = 16'd1; en = 1;
        step(530);

        // Reset in the middle of a high pulse.
        period = 24'd10; width = 16'd5;
        step(15);
        k = 0;
        while (!(m_run && m_pos == 2) && k < 40) begin step(1); k++; end
        rst = 1;
        step(1);
        chk("vs_after_rst", 32'(vs), 32'd0);
        rst = 0;
        step(12);

`ifdef VS_GEN_LOCK_EN
        // Lock to a 90-cycle reference on a 100-cycle program, then freewheel.
        chk_edge = 0;
        period = 24'd100; width = 16'd5; ref_stable = 1;
        for (int i = 0; i < 5; i++) begin
            ref_vs = 1; step(3);
            ref_vs = 0; step(87);
        end
        chk("locked_on_ref", 32'(locked), 32'd1);
        ref_stable = 0;
        for (int i = 0; i < 3; i++) begin
            ref_vs = 1; step(3);
            ref_vs = 0; step(87);
        end
        step(100);
        chk("freewheel_unlocked", 32'(locked), 32'd0);

        // Random reference activity and qualification.
        period = 24'd12; width = 16'd3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 6) == 0) ref_vs = ~ref_vs;
            if ($urandom_range(0, 40) == 0) ref_stable = ~ref_stable;
            if ($urandom_range(0, 50) == 0) width = 16'($urandom_range(0, 14));
            step(1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vs_gen.md
# vs_gen

Programmable vertical-sync generator: produces a periodic active-high VS pulse with run-time period and pulse width, counted in clock cycles. It is the source end of the VS path; its output feeds downstream timing logic and can be looped into the VS filter for self-test. An optional lock mode phase-aligns the generated VS to an external reference VS and free-runs (freewheels) when the reference is not stable.

## Interface
Parameters:
- C_PERIOD_BW, 24, width of period counter/input (max 16777215 clocks)
- C_WIDTH_BW, 16, width of pulse-width input
- C_FRAME_CNT_BW, 16, width of frame counter

Ports:
- CLK_I  in  1  clock; the block has one clock
- RST_I  in  1  reset, synchronous, active-high
- GEN_EN_I  in  1  generator enable
- PERIOD_CLKNUM_I  in  C_PERIOD_BW  VS rise-to-rise period in clocks
- WIDTH_CLKNUM_I  in  C_WIDTH_BW  VS high time in clocks
- REF_VS_I  in  1  reference VS (only with VS_GEN_LOCK_EN)
- REF_STABLE_I  in  1  reference qualified stable (only with VS_GEN_LOCK_EN)
- VS_O  out  1  generated VS, registered
- VS_POS_O  out  1  one-cycle pulse on the cycle VS_O first goes high
- FRAME_CNT_O  out  C_FRAME_CNT_BW  frames started since reset, wraps
- CFG_ERR_O  out  1  latched config invalid at last sample
- LOCKED_O  out  1  last frame start caused by reference edge (only with VS_GEN_LOCK_EN)

## Operation
- States: IDLE, ACTIVE (VS_O=1), BLANK (VS_O=0). Counter cnt (C_PERIOD_BW) counts 0..period-1 within a frame.
- Config valid: width ≥ 1, period ≥ 2, width < period (width zero-extended to C_PERIOD_BW for comparison).
- Shadow registers: PERIOD/WIDTH sampled only at frame start (IDLE exit or frame boundary); mid-frame input changes take effect at the next frame.
- IDLE: VS_O=0, cnt=0. If GEN_EN_I=1 and config valid → ACTIVE, frame start. If invalid → stay IDLE, CFG_ERR_O=1.
- ACTIVE: cnt increments; when cnt = width-1 → BLANK.
- BLANK: cnt increments; when cnt = period-1 → frame boundary: if GEN_EN_I=1 and config valid → ACTIVE, cnt=0; else → IDLE (CFG_ERR_O set if invalid).
- GEN_EN_I deassert mid-frame: current frame completes, then IDLE. No truncated pulses.
- Frame start: VS_POS_O=1 for one cycle, FRAME_CNT_O+1 (max → 0), CFG_ERR_O cleared.
- Reset mid-frame: all outputs to reset values next cycle, state IDLE.

## Timing
- Reset values: VS_O=0, VS_POS_O=0, FRAME_CNT_O=0, CFG_ERR_O=0, LOCKED_O=0, state IDLE.
- GEN_EN_I high at edge n in IDLE (valid config) → VS_O=1 and VS_POS_O=1 from edge n+1.
- VS_O high exactly width cycles; successive VS_POS_O exactly period cycles apart.
- All outputs registered; no combinational input-to-output path.

## Configuration
- Macro VS_GEN_LOCK_EN.
- Defined: REF_VS_I, REF_STABLE_I, LOCKED_O exist. Reference rising edge = REF_VS_I & ~REF_VS_I registered. On edge with REF_STABLE_I=1, GEN_EN_I=1, valid config, in any state: next cycle is a frame start (cnt=0, ACTIVE), aborting the current frame; LOCKED_O=1. Edge coinciding with natural boundary → single frame start, one VS_POS_O. Frame start without ref edge (freewheel) → LOCKED_O=0. REF_STABLE_I=0 → edges ignored, free-run on programmed period.
- Undefined: ports absent, free-running only.

## Structure
- Package vs_gen_pkg: state encoding (IDLE/ACTIVE/BLANK), default widths, config-valid function.
- Sub-module vs_edge_det: one-flop rising-edge detector for REF_VS_I, reused for VS_POS_O checks in bench.

## Test plan
- PERIOD=10, WIDTH=3, GEN_EN_I=1 after reset → VS_O high 3, low 7, VS_POS_O every 10 cycles, FRAME_CNT_O 0→1→2.
- WIDTH=10, PERIOD=10 → stays IDLE, VS_O=0, CFG_ERR_O=1; change to WIDTH=4 → frame starts, CFG_ERR_O=0.
- Change PERIOD 10→20 at cnt=5 → current frame 10 cycles, next 20.
- GEN_EN_I low at cnt=1 of 10-cycle frame → frame completes, VS_O low after, no further VS_POS_O.
- Lock build, PERIOD=100, REF rising every 90 with REF_STABLE_I=1 → VS_POS_O one cycle after each ref edge, spacing 90, LOCKED_O=1; drop REF_STABLE_I → spacing 100, LOCKED_O=0.
- FRAME_CNT_O preset run to 0xFFFF → next frame start wraps to 0; RST_I mid-ACTIVE → VS_O=0 next cycle.
